mem_fetch_ctrl: RTL and testbench
=================================

Name: mem_fetch_ctrl

Overview:
- Initiator/master for the instruction/data memory system.
- Drives address, write-data and write-enable into the memory system and captures its combinational read data.
- Runs a PC-based instruction fetch stream to a consumer over a valid/ready handshake.
- Arbitrates single-word store requests (program loader, core stores) into the same memory port.

Parameters:
DATA_WIDTH, 32, width of instruction and store data
ADDR_WIDTH, 32, width of PC and memory addresses
RESET_PC, 32'h0040_0000, PC loaded at reset and on start_i
PC_STEP, 4, PC increment per fetched instruction

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
start_i  input  1  begin fetching from RESET_PC (ignored while running)
stop_i  input  1  stop fetching after the held instruction is accepted
redirect_i  input  1  load PC from redirect_addr_i, flush held instruction
redirect_addr_i  input  ADDR_WIDTH  new PC; bits [1:0] forced to 0
instr_valid_o  output  1  instr_o/instr_pc_o valid
instr_ready_i  input  1  consumer accepts instruction
instr_o  output  DATA_WIDTH  fetched instruction
instr_pc_o  output  ADDR_WIDTH  address of instr_o
st_valid_i  input  1  store request; addr/data held stable until st_ready_o
st_addr_i  input  ADDR_WIDTH  store address (passed unmodified)
st_data_i  input  DATA_WIDTH  store data
st_ready_o  output  1  store committed this cycle
mem_addr_o  output  ADDR_WIDTH  to memory system address_i
mem_wdata_o  output  DATA_WIDTH  to memory system write_data
mem_we_o  output  1  to memory system write_enable_i
mem_rdata_i  input  DATA_WIDTH  from memory system instruction_o (combinational)
busy_o  output  1  running flag OR state != IDLE

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, running=0, pc=RESET_PC.
  - instr_valid_o=0, instr_o=0, instr_pc_o=0.
  - st_ready_o=0, mem_we_o=0, mem_wdata_o=0, mem_addr_o=RESET_PC, busy_o=0.
  - Reset mid-operation aborts any fetch or store. A store in the reset cycle has mem_we_o forced to 0, so no write occurs.
- States: IDLE, FETCH, HOLD, STORE.
- mem_addr_o:
  - STORE: st_addr_i.
  - All other states: pc.
  - mem_we_o=1 and st_ready_o=1 only in STORE, with mem_wdata_o=st_data_i; mem_wdata_o is 0 otherwise.
- IDLE:
  - st_valid_i → STORE; else start_i → pc=RESET_PC, running=1, FETCH.
  - st_valid_i and start_i together: STORE first, running=1 and pc=RESET_PC latched, then FETCH.
- FETCH (1 cycle):
  - At the edge: instr_o=mem_rdata_i, instr_pc_o=pc, instr_valid_o=1, pc=pc+PC_STEP mod 2^ADDR_WIDTH (wraps to 0), → HOLD.
- HOLD: instr_valid_o held high, instr_o/instr_pc_o stable until accepted. On instr_ready_i:
  - instr_valid_o=0.
  - Then st_valid_i → STORE; else stop_i or !running → IDLE with running=0; else FETCH.
  - Throughput: one instruction per 2 cycles.
- STORE (1 cycle): memory samples the write at the closing edge. Next state is FETCH if running, else IDLE.
- stop_i: clears running at the next edge in any state; the held instruction is still delivered.
- redirect_i (priority over the instr_ready_i/st_valid_i decisions):
  - pc=redirect_addr_i & ~3; instr_valid_o=0 (held instruction discarded even if instr_ready_i=1 the same cycle).
  - HOLD/FETCH → FETCH.
  - STORE → store completes, then FETCH.
  - IDLE → pc updated, stay IDLE.
- Fetch latency: an instruction is visible 1 cycle after entering FETCH. Stores wait at most until the held instruction is accepted.

Test Plan:
- Reset, then start_i pulse, memory returns 32'h2000_0001@0x0040_0000 and 32'h2000_0002@0x0040_0004, instr_ready_i=1 → instr_valid_o high 1 cycle after FETCH with instr_pc_o=0x0040_0000, then 0x0040_0004, alternating valid/non-valid cycles.
- Hold instr_ready_i=0 for 5 cycles → instr_o/instr_pc_o/instr_valid_o stable and no new mem read address change (mem_addr_o=0x0040_0004); accept on cycle 6 → next fetch begins.
- Store in IDLE: st_valid_i=1, st_addr_i=0x1001_0000, st_data_i=0xDEAD_BEEF → exactly one cycle with mem_we_o=1, mem_addr_o=0x1001_0000, mem_wdata_o=0xDEAD_BEEF, st_ready_o=1; subsequent read of that address returns 0xDEAD_BEEF.
- Redirect in HOLD with instr_ready_i=1 same cycle, redirect_addr_i=0x0040_0103 → held instruction dropped, next instr_pc_o=0x0040_0100.
- pc=0xFFFF_FFFC fetch → next instr_pc_o=0x0000_0000; stop_i during HOLD → instruction delivered, then IDLE, busy_o=0.
- Assert reset during STORE → mem_we_o=0 immediately, all outputs at reset values, pc=RESET_PC.

Source files
------------

// File: rtl/mem_fetch_ctrl.sv
// Memory-port master: runs a PC-driven instruction fetch stream to a consumer
// and merges single-word store requests into the same memory port.
module mem_fetch_ctrl #(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h0040_0000,
   parameter int                    PC_STEP    = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start_i,
   input  logic                  stop_i,
   input  logic                  redirect_i,
   input  logic [ADDR_WIDTH-1:0] redirect_addr_i,
   output logic                  instr_valid_o,
   input  logic                  instr_ready_i,
   output logic [DATA_WIDTH-1:0] instr_o,
   output logic [ADDR_WIDTH-1:0] instr_pc_o,
   input  logic                  st_valid_i,
   input  logic [ADDR_WIDTH-1:0] st_addr_i,
   input  logic [DATA_WIDTH-1:0] st_data_i,
   output logic                  st_ready_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [DATA_WIDTH-1:0] mem_wdata_o,
   output logic                  mem_we_o,
   input  logic [DATA_WIDTH-1:0] mem_rdata_i,
   output logic                  busy_o,
   output logic [1:0]            dbg_state_o
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are
   // both high. The instruction side holds instr_o/instr_pc_o stable while
   // instr_valid_o is high; the store side expects st_addr_i/st_data_i stable
   // until st_ready_o, which is high exactly in the cycle the write commits.

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2,
      STORE = 2'd3
   } state_t;

   state_t                state;
   state_t                state_nxt;
   logic                  running;
   logic                  running_nxt;
   logic [ADDR_WIDTH-1:0] pc;
   logic [ADDR_WIDTH-1:0] pc_nxt;
   logic                  instr_valid;
   logic                  valid_nxt;
   logic [DATA_WIDTH-1:0] instr_q;
   logic [DATA_WIDTH-1:0] instr_nxt;
   logic [ADDR_WIDTH-1:0] instr_pc_q;
   logic [ADDR_WIDTH-1:0] ipc_nxt;
   logic [ADDR_WIDTH-1:0] redir_pc;
   logic [ADDR_WIDTH-1:0] pc_inc;

   assign redir_pc = redirect_addr_i & ~ADDR_WIDTH'(3);
   assign pc_inc   = pc + ADDR_WIDTH'(PC_STEP);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         running     <= 1'b0;
         pc          <= RESET_PC;
         instr_valid <= 1'b0;
         instr_q     <= '0;
         instr_pc_q  <= '0;
      end else begin
         state       <= state_nxt;
         running     <= running_nxt;
         pc          <= pc_nxt;
         instr_valid <= valid_nxt;
         instr_q     <= instr_nxt;
         instr_pc_q  <= ipc_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      running_nxt = running;
      pc_nxt      = pc;
      valid_nxt   = instr_valid;
      instr_nxt   = instr_q;
      ipc_nxt     = instr_pc_q;

      case (state)
         IDLE: begin
            if (redirect_i) begin
               pc_nxt = redir_pc;
            end else if (st_valid_i) begin
               // A start arriving with a store is remembered and run after it.
               state_nxt = STORE;
               if (start_i) begin
                  running_nxt = 1'b1;
                  pc_nxt      = RESET_PC;
               end
            end else if (start_i) begin
               running_nxt = 1'b1;
               pc_nxt      = RESET_PC;
               state_nxt   = FETCH;
            end
         end

         FETCH: begin
            if (redirect_i) begin
               pc_nxt    = redir_pc;
               valid_nxt = 1'b0;
            end else begin
               instr_nxt = mem_rdata_i;
               ipc_nxt   = pc;
               valid_nxt = 1'b1;
               pc_nxt    = pc_inc;
               state_nxt = HOLD;
            end
         end

         HOLD: begin
            if (redirect_i) begin
               // Redirect wins even over a same-cycle accept: the word is dropped.
               pc_nxt    = redir_pc;
               valid_nxt = 1'b0;
               state_nxt = FETCH;
            end else if (instr_ready_i) begin
               valid_nxt = 1'b0;
               if (st_valid_i) begin
                  state_nxt = STORE;
               end else if (stop_i || !running) begin
                  running_nxt = 1'b0;
                  state_nxt   = IDLE;
               end else begin
                  state_nxt = FETCH;
               end
            end
         end

         STORE: begin
            if (redirect_i) begin
               pc_nxt    = redir_pc;
               state_nxt = FETCH;
            end else begin
               state_nxt = running ? FETCH : IDLE;
            end
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase

      if (stop_i) begin
         running_nxt = 1'b0;
      end
   end

   // The reset term keeps a store from writing during an asynchronous reset.
   assign mem_we_o      = (state == STORE) && reset;
   assign st_ready_o    = mem_we_o;
   assign mem_addr_o    = (state == STORE) ? st_addr_i : pc;
   assign mem_wdata_o   = (state == STORE) ? st_data_i : '0;
   assign instr_valid_o = instr_valid;
   assign instr_o       = instr_q;
   assign instr_pc_o    = instr_pc_q;
   assign busy_o        = running || (state != IDLE);
   assign dbg_state_o   = state;

endmodule

// File: tb/tb_mem_fetch_ctrl.sv
// Bench for mem_fetch_ctrl: directed walk-through of the fetch/store/redirect
// scenarios, then randomized traffic against a flag-based reference model.
module tb_mem_fetch_ctrl;

   localparam logic [31:0] RPC = 32'h0040_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        start_i, stop_i, redirect_i;
   logic [31:0] redirect_addr_i;
   logic        instr_valid_o, instr_ready_i;
   logic [31:0] instr_o, instr_pc_o;
   logic        st_valid_i;
   logic [31:0] st_addr_i, st_data_i;
   logic        st_ready_o;
   logic [31:0] mem_addr_o, mem_wdata_o;
   logic        mem_we_o;
   logic [31:0] mem_rdata_i;
   logic        busy_o;
   logic [1:0]  dbg_state_o;

   int total = 0;
   int bad   = 0;

   // Memory image: written words, otherwise a pattern derived from the address.
   logic [31:0] mem [logic [31:0]];

   // Reference model: what is held for the consumer, what happens this cycle.
   logic [31:0] m_pc, m_instr, m_ipc;
   logic        m_run, m_have, m_fetch, m_store;
   logic        st_done;

   mem_fetch_ctrl dut (
      .clk             (clk),
      .reset           (reset),
      .start_i         (start_i),
      .stop_i          (stop_i),
      .redirect_i      (redirect_i),
      .redirect_addr_i (redirect_addr_i),
      .instr_valid_o   (instr_valid_o),
      .instr_ready_i   (instr_ready_i),
      .instr_o         (instr_o),
      .instr_pc_o      (instr_pc_o),
      .st_valid_i      (st_valid_i),
      .st_addr_i       (st_addr_i),
      .st_data_i       (st_data_i),
      .st_ready_o      (st_ready_o),
      .mem_addr_o      (mem_addr_o),
      .mem_wdata_o     (mem_wdata_o),
      .mem_we_o        (mem_we_o),
      .mem_rdata_i     (mem_rdata_i),
      .busy_o          (busy_o),
      .dbg_state_o     (dbg_state_o)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return 32'h2000_0000 + ((a - RPC) >> 2) + 32'd1;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %08h want %08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pc = RPC; m_run = 1'b0; m_have = 1'b0; m_fetch = 1'b0; m_store = 1'b0;
      m_instr = '0; m_ipc = '0; st_done = 1'b0;
   endtask

   task automatic model_step();
      logic [31:0] redir;
      redir = redirect_addr_i & 32'hFFFF_FFFC;
      if (m_store) begin
         m_store = 1'b0;
         if (redirect_i) begin
            m_pc = redir; m_fetch = 1'b1;
         end else begin
            m_fetch = m_run;
         end
      end else if (m_fetch) begin
         if (redirect_i) begin
            m_pc = redir;
         end else begin
            m_have = 1'b1; m_instr = mem_rd(m_pc); m_ipc = m_pc;
            m_pc = m_pc + 32'd4; m_fetch = 1'b0;
         end
      end else if (m_have) begin
         if (redirect_i) begin
            m_have = 1'b0; m_pc = redir; m_fetch = 1'b1;
         end else if (instr_ready_i) begin
            m_have = 1'b0;
            if (st_valid_i) m_store = 1'b1;
            else if (stop_i || !m_run) m_run = 1'b0;
            else m_fetch = 1'b1;
         end
      end else begin
         if (redirect_i) begin
            m_pc = redir;
         end else if (st_valid_i) begin
            m_store = 1'b1;
            if (start_i) begin m_run = 1'b1; m_pc = RPC; end
         end else if (start_i) begin
            m_run = 1'b1; m_pc = RPC; m_fetch = 1'b1;
         end
      end
      if (stop_i) m_run = 1'b0;
   endtask

   // Called at a falling edge with inputs driven: serve the read, then compare.
   task automatic drive_eval();
      #1 mem_rdata_i = mem_rd(mem_addr_o);
      #1;
      chk("instr_valid", 32'(instr_valid_o), 32'(m_have));
      if (m_have) begin
         chk("instr", instr_o, m_instr);
         chk("instr_pc", instr_pc_o, m_ipc);
      end
      chk("busy", 32'(busy_o), 32'(m_run | m_have | m_fetch | m_store));
      chk("mem_we", 32'(mem_we_o), 32'(m_store));
      chk("st_ready", 32'(st_ready_o), 32'(m_store));
      chk("mem_addr", mem_addr_o, m_store ? st_addr_i : m_pc);
      chk("mem_wdata", mem_wdata_o, m_store ? st_data_i : 32'd0);
   endtask

   task automatic advance();
      st_done = m_store;
      model_step();
      if (mem_we_o) mem[mem_addr_o] = mem_wdata_o;
      @(negedge clk);
   endtask

   task automatic clear_inputs();
      start_i = 1'b0; stop_i = 1'b0; redirect_i = 1'b0; redirect_addr_i = '0;
      instr_ready_i = 1'b0; st_valid_i = 1'b0; st_addr_i = '0; st_data_i = '0;
   endtask

   task automatic reset_checks(input string tag);
      chk({tag, " we"}, 32'(mem_we_o), 32'd0);
      chk({tag, " st_ready"}, 32'(st_ready_o), 32'd0);
      chk({tag, " addr"}, mem_addr_o, RPC);
      chk({tag, " wdata"}, mem_wdata_o, 32'd0);
      chk({tag, " valid"}, 32'(instr_valid_o), 32'd0);
      chk({tag, " instr"}, instr_o, 32'd0);
      chk({tag, " instr_pc"}, instr_pc_o, 32'd0);
      chk({tag, " busy"}, 32'(busy_o), 32'd0);
   endtask

   initial begin
      clear_inputs();
      mem_rdata_i = '0;
      reset = 1'b0;
      @(posedge clk);
      #2;
      reset_checks("reset");
      chk("reset dbg_state", 32'(dbg_state_o), 32'd0);
      model_reset();
      @(negedge clk);
      reset = 1'b1;

      // Start, hold the first word for five cycles, then stream with ready.
      start_i = 1'b1; instr_ready_i = 1'b1;
      drive_eval(); advance();
      start_i = 1'b0; instr_ready_i = 1'b0;
      drive_eval();
      chk("fetch0 addr", mem_addr_o, 32'h0040_0000);
      advance();
      for (int k = 0; k < 5; k++) begin
         drive_eval();
         chk("hold valid", 32'(instr_valid_o), 32'd1);
         chk("hold instr", instr_o, 32'h2000_0001);
         chk("hold pc", instr_pc_o, 32'h0040_0000);
         chk("hold addr", mem_addr_o, 32'h0040_0004);
         advance();
      end
      instr_ready_i = 1'b1;
      drive_eval(); chk("accept valid", 32'(instr_valid_o), 32'd1); advance();
      drive_eval(); chk("gap valid", 32'(instr_valid_o), 32'd0);
      chk("fetch1 addr", mem_addr_o, 32'h0040_0004); advance();
      drive_eval(); chk("instr1", instr_o, 32'h2000_0002);
      chk("instr1 pc", instr_pc_o, 32'h0040_0004); advance();
      drive_eval(); chk("gap2 valid", 32'(instr_valid_o), 32'd0); advance();
      stop_i = 1'b1;
      drive_eval(); chk("stop delivers", 32'(instr_valid_o), 32'd1);
      chk("stop pc", instr_pc_o, 32'h0040_0008); advance();
      stop_i = 1'b0; instr_ready_i = 1'b0;
      drive_eval(); chk("stop idle busy", 32'(busy_o), 32'd0); advance();

      // Store from IDLE, then read it back via a redirected fetch.
      st_valid_i = 1'b1; st_addr_i = 32'h1001_0000; st_data_i = 32'hDEAD_BEEF;
      drive_eval(); advance();
      drive_eval();
      chk("store we", 32'(mem_we_o), 32'd1);
      chk("store ready", 32'(st_ready_o), 32'd1);
      chk("store addr", mem_addr_o, 32'h1001_0000);
      chk("store data", mem_wdata_o, 32'hDEAD_BEEF);
      advance();
      st_valid_i = 1'b0;
      drive_eval(); chk("store done we", 32'(mem_we_o), 32'd0); advance();
      start_i = 1'b1; drive_eval(); advance(); start_i = 1'b0;
      redirect_i = 1'b1; redirect_addr_i = 32'h1001_0000;
      drive_eval(); advance();
      redirect_i = 1'b0;
      drive_eval(); chk("readback addr", mem_addr_o, 32'h1001_0000); advance();

      // Redirect with a same-cycle accept drops the held word.
      instr_ready_i = 1'b1; redirect_i = 1'b1; redirect_addr_i = 32'h0040_0103;
      drive_eval(); chk("readback data", instr_o, 32'hDEAD_BEEF);
      chk("readback pc", instr_pc_o, 32'h1001_0000); advance();
      redirect_i = 1'b0; instr_ready_i = 1'b0;
      drive_eval(); chk("dropped valid", 32'(instr_valid_o), 32'd0);
      chk("redir addr", mem_addr_o, 32'h0040_0100); advance();
      drive_eval(); chk("redir pc", instr_pc_o, 32'h0040_0100);
      chk("redir instr", instr_o, 32'h2000_0041);

      // PC wrap at the top of the address space, then stop.
      redirect_i = 1'b1; redirect_addr_i = 32'hFFFF_FFFE; instr_ready_i = 1'b1;
      advance();
      redirect_i = 1'b0; instr_ready_i = 1'b0;
      drive_eval(); chk("top addr", mem_addr_o, 32'hFFFF_FFFC); advance();
      instr_ready_i = 1'b1;
      drive_eval(); chk("top pc", instr_pc_o, 32'hFFFF_FFFC);
      chk("wrapped addr", mem_addr_o, 32'h0000_0000); advance();
      instr_ready_i = 1'b0; drive_eval(); advance();
      stop_i = 1'b1; instr_ready_i = 1'b1;
      drive_eval(); chk("wrap pc", instr_pc_o, 32'h0000_0000);
      chk("wrap valid", 32'(instr_valid_o), 32'd1); advance();
      stop_i = 1'b0; instr_ready_i = 1'b0;
      drive_eval(); chk("wrap idle busy", 32'(busy_o), 32'd0); advance();

      // Reset landing in the middle of a store cycle.
      st_valid_i = 1'b1; st_addr_i = 32'h1001_0004; st_data_i = 32'h1234_5678;
      drive_eval(); advance();
      #1 chk("pre-reset we", 32'(mem_we_o), 32'd1);
      reset = 1'b0;
      #1 reset_checks("mid reset");
      model_reset();
      clear_inputs();
      @(negedge clk);
      reset = 1'b1;

      // Randomized traffic.
      for (int n = 0; n < 3000; n++) begin
         start_i       = ($urandom_range(0, 5) == 0);
         stop_i        = ($urandom_range(0, 23) == 0);
         instr_ready_i = ($urandom_range(0, 3) != 0);
         redirect_i    = ($urandom_range(0, 15) == 0);
         case ($urandom_range(0, 3))
            0:       redirect_addr_i = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            default: redirect_addr_i = RPC + 32'($urandom_range(0, 1023));
         endcase
         if (st_valid_i && st_done) st_valid_i = 1'b0;
         if (!st_valid_i && $urandom_range(0, 7) == 0) begin
            st_valid_i = 1'b1;
            st_addr_i  = RPC + (32'($urandom_range(0, 255)) << 2);
            st_data_i  = $urandom;
         end
         drive_eval();
         advance();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
